spi_slave_regbank: RTL

- FPGA-side SPI responder (slave) for the ARM SPI master on a dedicated chip select. Receives 16-bit command frames and maintains an internal 8-bit control register file.
- Register outputs drive on-board control, e.g. gpio-style enables and resets for the ADC/DAC.
- SCLK, CS and MOSI are oversampled in the system clock domain. Reads return register contents on MISO in the same frame.

---
 rtl/spi_slave_regbank_if.sv | 25 ++
 rtl/spi_slave_regbank.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regbank_if.sv
// SPI pin bundle for spi_slave_regbank: SCLK/CSn/MOSI from the master,
// MISO plus its output enable back; master/slave modports.
interface spi_slave_regbank_if;
  logic spi_clk;
  logic spi_csn;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_clk,
    output spi_csn,
    output spi_mosi,
    input  spi_miso,
    input  spi_miso_oe
  );

  modport slave (
    input  spi_clk,
    input  spi_csn,
    input  spi_mosi,
    output spi_miso,
    output spi_miso_oe
  );
endinterface

// File: rtl/spi_slave_regbank.sv
// SPI mode-0 slave with an 8-bit register file; 16-bit frames {rw,addr[6:0],data}.
// Ports: clk, rst_n (async low), spi (slave modport: spi_clk/csn/mosi in,
// spi_miso/spi_miso_oe out), regs_flat, wr_stb/wr_addr/wr_data, frame_abort.
// SPI_SLAVE_AUTOINC_EN: burst bytes to addr+1, addr+2, ... after the first.
module spi_slave_regbank #(
  parameter int         NREGS       = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RST_VAL     = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_slave_regbank_if.slave spi,
  output logic [8*NREGS-1:0] regs_flat,
  output logic               wr_stb,
  output logic [6:0]         wr_addr,
  output logic [7:0]         wr_data,
  output logic               frame_abort
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [7:0] NREGS_L = 8'(NREGS);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_e;

  logic [SYNC_STAGES-1:0] sclk_q, csn_q, mosi_q;
  logic sclk_p_q, csn_p_q;
  logic sclk_s, csn_s, mosi_s;
  logic rise, fall, csn_fall;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  sh_q, sh_d;
  logic        rw_q, rw_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  so_q, so_d;
  logic        miso_q, miso_d;
  logic [7:0]  regs_q [NREGS];
  logic [7:0]  regs_d [NREGS];
  logic        wr_stb_q, wr_stb_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        abort_q, abort_d;
`ifdef SPI_SLAVE_AUTOINC_EN
  logic        burst_q, burst_d;
`endif

  logic [7:0]  byte_in;
  logic [6:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        oe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q   <= '0;
      csn_q    <= '1;
      mosi_q   <= '0;
      sclk_p_q <= 1'b0;
      csn_p_q  <= 1'b1;
    end else begin
      sclk_q   <= {sclk_q[SYNC_STAGES-2:0], spi.spi_clk};
      csn_q    <= {csn_q[SYNC_STAGES-2:0], spi.spi_csn};
      mosi_q   <= {mosi_q[SYNC_STAGES-2:0], spi.spi_mosi};
      sclk_p_q <= sclk_s;
      csn_p_q  <= csn_s;
    end
  end

  assign sclk_s   = sclk_q[SYNC_STAGES-1];
  assign csn_s    = csn_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  // SCLK edges are ignored whenever the synced chip select is high.
  assign rise     = ~csn_s & sclk_s & ~sclk_p_q;
  assign fall     = ~csn_s & ~sclk_s & sclk_p_q;
  assign csn_fall = csn_p_q & ~csn_s;

  assign byte_in  = {sh_q, mosi_s};
  // In CMD the address is completing this cycle; in DATA it is the next burst address.
  assign rd_addr  = (state_q == CMD) ? byte_in[6:0] : addr_q + 7'd1;

  always_comb begin
    rd_data = 8'h00;
    if ({1'b0, rd_addr} < NREGS_L) rd_data = regs_q[rd_addr[AW-1:0]];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    so_d      = so_q;
    miso_d    = miso_q;
    regs_d    = regs_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    abort_d   = 1'b0;
`ifdef SPI_SLAVE_AUTOINC_EN
    burst_d   = burst_q;
`endif
    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (csn_fall) begin
          cnt_d   = 4'd0;
          state_d = CMD;
`ifdef SPI_SLAVE_AUTOINC_EN
          burst_d = 1'b0;
`endif
        end
      end
      CMD: begin
        if (csn_s) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (rise) begin
          sh_d  = byte_in[6:0];
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            rw_d    = byte_in[7];
            addr_d  = byte_in[6:0];
            so_d    = rd_data;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (csn_s) begin
          state_d = IDLE;
          abort_d = 1'b1;
`ifdef SPI_SLAVE_AUTOINC_EN
          // Ending exactly after a completed burst byte is a clean stop.
          if (burst_q && cnt_q == 4'd8) abort_d = 1'b0;
`endif
        end else if (rise) begin
          sh_d  = byte_in[6:0];
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            if (!rw_q && ({1'b0, addr_q} < NREGS_L)) begin
              regs_d[addr_q[AW-1:0]] = byte_in;
              wr_stb_d  = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = byte_in;
            end
`ifdef SPI_SLAVE_AUTOINC_EN
            cnt_d   = 4'd8;
            addr_d  = addr_q + 7'd1;
            so_d    = rd_data;
            burst_d = 1'b1;
`else
            state_d = DONE;
`endif
          end
        end else if (fall && rw_q) begin
          miso_d = so_q[7];
          so_d   = {so_q[6:0], 1'b0};
        end
      end
      DONE: begin
        if (csn_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      sh_q      <= 7'd0;
      rw_q      <= 1'b0;
      addr_q    <= 7'd0;
      so_q      <= 8'h00;
      miso_q    <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= RST_VAL;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= 7'd0;
      wr_data_q <= 8'h00;
      abort_q   <= 1'b0;
`ifdef SPI_SLAVE_AUTOINC_EN
      burst_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      so_q      <= so_d;
      miso_q    <= miso_d;
      regs_q    <= regs_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      abort_q   <= abort_d;
`ifdef SPI_SLAVE_AUTOINC_EN
      burst_q   <= burst_d;
`endif
    end
  end

  assign oe              = ~csn_s & (state_q == DATA) & rw_q;
  assign spi.spi_miso_oe = oe;
  assign spi.spi_miso    = oe & miso_q;

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs_q[g];
  end

  assign wr_stb      = wr_stb_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_abort = abort_q;
endmodule
